instr_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the RISC-V core's fetch stage. It succeeds the fixed 32x32 combinational instruction ROM with:
- byte-addressed fetch using a req/ready/valid handshake
- a run-time programming (write) port for the loader/testbench
- a hardware clear sequencer after reset
- misaligned/out-of-range fault reporting

It sits between the PC register and the decode stage.

---
 rtl/instr_mem_sync.sv | 100 ++++++++++
 tb/tb_instr_mem_sync.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the fetch stage: byte-addressed fetch with one-cycle latency,
// a run-time programming port, a post-reset clear sequencer, and misaligned/out-of-range fault reporting.
module instr_mem_sync #(
  parameter  int                XLEN      = 32,
  parameter  int                DEPTH     = 64,
  localparam int                ADDR_W    = $clog2(DEPTH),
  parameter  logic [XLEN-1:0]   FILL_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [XLEN-1:0]   fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_instr,
  output logic              fetch_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_data,
  output logic              busy
);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              fetch_valid_q, fetch_fault_q;
  logic [XLEN-1:0]   fetch_instr_q;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              accept, misaligned, out_of_range, fault;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [XLEN-1:0]   wr_data;

  assign fetch_ready  = (state_q == READY);
  assign busy         = (state_q == CLEAR);
  assign accept       = fetch_req & fetch_ready;
  assign rd_idx       = fetch_addr[ADDR_W+1:2];
  assign misaligned   = |fetch_addr[1:0];
  assign out_of_range = |(fetch_addr >> (ADDR_W + 2));
  assign fault        = misaligned | out_of_range;

  // Single write port: the clear sequencer owns it in CLEAR, the loader in READY.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_idx    = prog_addr;
    wr_data   = prog_data;
    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx_q;
        wr_data   = FILL_WORD;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        wr_en = prog_we;
      end
      default: state_d = CLEAR;
    endcase
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Read uses the pre-write array contents, so a same-edge write is seen only by later fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_instr_q <= FILL_WORD;
    end else begin
      fetch_valid_q <= accept;
      fetch_fault_q <= accept & fault;
      if (accept) fetch_instr_q <= fault ? FILL_WORD : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: clear sequence, program/fetch, throughput, faults,
// read-before-write and mid-operation reset.
module tb_instr_mem_sync;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [XLEN-1:0]   fetch_addr;
  logic              fetch_ready, fetch_valid, fetch_fault, busy;
  logic [XLEN-1:0]   fetch_instr;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [XLEN-1:0]   prog_data;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  instr_mem_sync #(.XLEN(XLEN), .DEPTH(DEPTH), .FILL_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_instr", fetch_instr, NOP);
    chk("rst_ready", 32'(fetch_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);

    // Clear: busy spans exactly DEPTH cycles from reset deassertion.
    reset = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("clear_len", 32'(cnt), 32'd64);
    chk("clr_ready", 32'(fetch_ready), 32'd1);
    chk("clr_busy",  32'(busy), 32'd0);

    fetch(32'h0);
    chk("f0_valid", 32'(fetch_valid), 32'd1);
    chk("f0_instr", fetch_instr, NOP);
    chk("f0_fault", 32'(fetch_fault), 32'd0);
    tick();
    chk("idle_valid", 32'(fetch_valid), 32'd0);
    chk("idle_hold",  fetch_instr, NOP);

    prog(6'd5, 32'h001101B3);
    fetch(32'h14);
    chk("p5_valid", 32'(fetch_valid), 32'd1);
    chk("p5_instr", fetch_instr, 32'h001101B3);
    chk("p5_fault", 32'(fetch_fault), 32'd0);

    // Back-to-back fetches at full throughput.
    for (int i = 0; i < 4; i++) prog(ADDR_W'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'(4 * i);
      tick();
      chk("b2b_valid", 32'(fetch_valid), 32'd1);
      chk("b2b_instr", fetch_instr, 32'hA0 + 32'(i));
    end
    fetch_req = 1'b0;
    tick();
    chk("b2b_end_valid", 32'(fetch_valid), 32'd0);
    chk("b2b_end_hold",  fetch_instr, 32'hA3);

    // Faults and top-of-range word.
    prog(6'd63, 32'hDEADBEEF);
    fetch(32'h06);
    chk("mis_valid", 32'(fetch_valid), 32'd1);
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_instr", fetch_instr, NOP);
    fetch(32'h100);
    chk("oor_fault", 32'(fetch_fault), 32'd1);
    chk("oor_instr", fetch_instr, NOP);
    fetch(32'hFC);
    chk("top_fault", 32'(fetch_fault), 32'd0);
    chk("top_instr", fetch_instr, 32'hDEADBEEF);
    fetch(32'h8000_0000);
    chk("hi_fault", 32'(fetch_fault), 32'd1);

    // Same-edge write and fetch of word 7 returns the old contents.
    prog(6'd7, 32'h11111111);
    prog_we = 1'b1; prog_addr = 6'd7; prog_data = 32'h22222222;
    fetch_req = 1'b1; fetch_addr = 32'h1C;
    tick();
    prog_we = 1'b0;
    chk("rbw_old", fetch_instr, 32'h11111111);
    tick();
    fetch_req = 1'b0;
    chk("rbw_new", fetch_instr, 32'h22222222);

    // Reset mid-operation with a fetch and a write on the reset edge.
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h14;
    prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'h12345678;
    tick();
    reset = 1'b0; fetch_req = 1'b0; prog_we = 1'b0;
    chk("mid_valid", 32'(fetch_valid), 32'd0);
    chk("mid_busy",  32'(busy), 32'd1);
    chk("mid_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    // Word 0 is already cleared here, so an honoured write would persist.
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h77777777;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    prog_we = 1'b0; fetch_req = 1'b0;
    chk("clr_fetch_drop", 32'(fetch_valid), 32'd0);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("reclear_len", 32'(cnt), 32'd58);
    fetch(32'h14);
    chk("reclr_w5_valid", 32'(fetch_valid), 32'd1);
    chk("reclr_w5", fetch_instr, NOP);
    fetch(32'h0);
    chk("clr_prog_drop", fetch_instr, NOP);
    fetch(32'h1C);
    chk("reclr_w7", fetch_instr, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
